// File: rtl/sort_serializer.sv
`default_nettype none
// ============================================================================
// Module      : sort_serializer
// Description : Output stage that sits directly after sort_top. On each
//               valid_in pulse it captures a DEPTH-wide sorted vector and
//               streams it out one element per beat, starting at index 0,
//               over a valid/ready interface. Two vector buffers work as a
//               ping-pong pair. A vector that arrives while both buffers are
//               busy is dropped, and the sticky overflow flag is set.
// Ports       :
//   clk        in   clock, all logic on posedge
//   rst        in   synchronous active-high reset
//   valid_in   in   one-cycle pulse, sorted[] holds a complete vector
//   sorted     in   DEPTH x WIDTH sorted vector, sorted[0] is the smallest
//   in_ready   out  a valid_in in this cycle is accepted (status only)
//   out_data   out  current element
//   out_idx    out  index of out_data within its vector
//   out_valid  out  out_data/out_idx/out_last are valid
//   out_ready  in   consumer accepts a beat when out_valid && out_ready
//   out_last   out  high on the beat that carries element DEPTH-1
//   overflow   out  sticky, at least one vector was dropped
// Revision    : 1.0  initial release
// ============================================================================
module sort_serializer #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int IDXW  = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        valid_in,
  input  logic [DEPTH-1:0][WIDTH-1:0] sorted,
  output logic                        in_ready,
  output logic [WIDTH-1:0]            out_data,
  output logic [IDXW-1:0]             out_idx,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        out_last,
  output logic                        overflow
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  logic [DEPTH-1:0][WIDTH-1:0] vec_buf_q [2];
  logic [DEPTH-1:0][WIDTH-1:0] vec_buf_d [2];
  logic [1:0]                  occ_q, occ_d;
  logic                        wr_ptr_q, wr_ptr_d;
  logic                        rd_ptr_q, rd_ptr_d;
  logic [IDXW-1:0]             rd_idx_q, rd_idx_d;
  logic                        overflow_q, overflow_d;

  logic beat;
  logic final_beat;
  logic capture;

  assign out_valid  = (occ_q != 2'd0);
  assign beat       = out_valid && out_ready;
  assign final_beat = beat && (rd_idx_q == LAST_IDX);

  // The final beat of the draining buffer frees its slot in the same cycle.
  // When both buffers are full, wr_ptr points at that draining buffer, so
  // overwriting it on this edge is safe.
  assign in_ready = (occ_q != 2'd2) || final_beat;
  assign capture  = valid_in && in_ready;

  // The buffer contents are only visible while out_valid is high. This keeps
  // out_data at zero whenever nothing is queued, without resetting the
  // storage arrays.
  assign out_data = out_valid ? vec_buf_q[rd_ptr_q][rd_idx_q] : '0;
  assign out_idx  = rd_idx_q;
  assign out_last = out_valid && (rd_idx_q == LAST_IDX);
  assign overflow = overflow_q;

  always_comb begin
    vec_buf_d  = vec_buf_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    rd_idx_d   = rd_idx_q;
    overflow_d = overflow_q;

    if (capture) begin
      vec_buf_d[wr_ptr_q] = sorted;
      wr_ptr_d            = ~wr_ptr_q;
    end else if (valid_in) begin
      overflow_d = 1'b1;
    end

    if (beat) begin
      if (final_beat) begin
        rd_idx_d = '0;
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_idx_d = rd_idx_q + IDXW'(1);
      end
    end

    // A capture and a final beat in the same cycle cancel out.
    occ_d = occ_q + {1'b0, capture} - {1'b0, final_beat};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= 2'd0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_idx_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      occ_q      <= occ_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_idx_q   <= rd_idx_d;
      overflow_q <= overflow_d;
    end
  end

  // The storage needs no reset. Its contents are masked by out_valid until a
  // capture writes them.
  always_ff @(posedge clk) begin
    vec_buf_q <= vec_buf_d;
  end

endmodule
`default_nettype wire

// File: tb/tb_sort_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_serializer
// Description : Self-checking bench for sort_serializer. A queue-based model
//               holds the expected beat stream and is compared with the DUT
//               on every negedge. Directed scenarios add literal checks.
// Revision    : 1.0  initial release
// ============================================================================
module tb_sort_serializer;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic                        valid_in = 1'b0;
  logic [DEPTH-1:0][WIDTH-1:0] sorted = '0;
  logic                        in_ready;
  logic [WIDTH-1:0]            out_data;
  logic [2:0]                  out_idx;
  logic                        out_valid;
  logic                        out_ready = 1'b0;
  logic                        out_last;
  logic                        overflow;

  sort_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .sorted    (sorted),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [WIDTH-1:0] data;
    int               idx;
  } beat_t;

  beat_t            exp_q[$];
  bit               exp_ovf = 1'b0;
  bit               check_en = 1'b0;
  logic [WIDTH-1:0] got[$];
  logic [WIDTH-1:0] lasts[$];

  always @(negedge clk) begin
    if (check_en) begin
      int  nvec;
      bit  head_last;
      bit  exp_rdy;
      bit  mbeat;
      nvec      = (exp_q.size() + DEPTH - 1) / DEPTH;
      head_last = (exp_q.size() > 0) && (exp_q[0].idx == DEPTH - 1);
      mbeat     = (exp_q.size() > 0) && out_ready;
      exp_rdy   = (nvec < 2) || (mbeat && head_last);

      if (exp_q.size() > 0) begin
        chk("out_valid", out_valid, 1);
        chk("out_data", out_data, exp_q[0].data);
        chk("out_idx", out_idx, exp_q[0].idx);
        chk("out_last", out_last, head_last);
      end else begin
        chk("out_valid_idle", out_valid, 0);
      end
      chk("in_ready", in_ready, exp_rdy);
      chk("overflow", overflow, exp_ovf);

      if (!rst && out_valid && out_ready) begin
        got.push_back(out_data);
        if (out_last) lasts.push_back(out_data);
      end

      if (rst) begin
        exp_q.delete();
        exp_ovf = 1'b0;
      end else begin
        if (mbeat) void'(exp_q.pop_front());
        if (valid_in) begin
          if (exp_rdy) begin
            for (int i = 0; i < DEPTH; i++) begin
              beat_t b;
              b.data = sorted[i];
              b.idx  = i;
              exp_q.push_back(b);
            end
          end else begin
            exp_ovf = 1'b1;
          end
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [DEPTH-1:0][WIDTH-1:0] v);
    sorted   = v;
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
    sorted   = '0;
  endtask

  function automatic logic [DEPTH-1:0][WIDTH-1:0] seq(input int base);
    logic [DEPTH-1:0][WIDTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = WIDTH'(base + i + 1);
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_got(input string name, input int exp[$]);
    bit ok;
    ok = (got.size() == exp.size());
    for (int i = 0; i < exp.size() && ok; i++)
      if (got[i] !== WIDTH'(exp[i])) ok = 1'b0;
    chk(name, ok ? 1 : 0, 1);
  endtask

  int t1[8] = '{1, 2, 3, 5, 7, 10, 18, 25};

  initial begin
    logic [DEPTH-1:0][WIDTH-1:0] v1;
    int exp[$];
    for (int i = 0; i < DEPTH; i++) v1[i] = WIDTH'(t1[i]);

    // reset state
    tick();
    check_en = 1'b1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b0;
    tick();

    // T1 single vector, the first element appears one cycle after capture
    out_ready = 1'b1;
    got.delete(); lasts.delete();
    pulse(v1);
    chk("t1_latency_valid", out_valid, 1);
    chk("t1_latency_data", out_data, 1);
    chk("t1_latency_idx", out_idx, 0);
    repeat (10) tick();
    exp = '{1, 2, 3, 5, 7, 10, 18, 25};
    chk_got("t1_stream", exp);
    chk("t1_last_count", lasts.size(), 1);
    chk("t1_last_value", (lasts.size() > 0) ? lasts[0] : 0, 25);

    // T2 backpressure
    got.delete();
    out_ready = 1'b1;
    pulse(v1);
    for (int i = 0; i < 40; i++) begin
      out_ready = ((i % 4) == 0 || (i % 4) == 3);
      tick();
    end
    chk_got("t2_stream", exp);
    out_ready = 1'b1;
    tick();

    // T3 two vectors two cycles apart, no gap between them
    got.delete(); lasts.delete();
    pulse(seq(0));
    tick();
    pulse(seq(10));
    repeat (20) tick();
    exp = '{1, 2, 3, 4, 5, 6, 7, 8, 11, 12, 13, 14, 15, 16, 17, 18};
    chk_got("t3_stream", exp);
    chk("t3_lasts", lasts.size(), 2);
    chk("t3_last0", (lasts.size() > 0) ? lasts[0] : 0, 8);
    chk("t3_last1", (lasts.size() > 1) ? lasts[1] : 0, 18);

    // T4 overflow on the third pulse
    got.delete();
    out_ready = 1'b0;
    pulse(seq(0));
    pulse(seq(10));
    chk("t4_in_ready_full", in_ready, 0);
    pulse(seq(20));
    chk("t4_overflow", overflow, 1);
    out_ready = 1'b1;
    repeat (24) tick();
    exp = '{1, 2, 3, 4, 5, 6, 7, 8, 11, 12, 13, 14, 15, 16, 17, 18};
    chk_got("t4_stream", exp);
    chk("t4_overflow_sticky", overflow, 1);
    do_reset();
    chk("t4_overflow_cleared", overflow, 0);

    // T5 a capture on the first vector's final beat is accepted
    got.delete();
    out_ready = 1'b0;
    pulse(seq(0));
    pulse(seq(10));
    out_ready = 1'b1;
    repeat (7) tick();
    sorted   = seq(20);
    valid_in = 1'b1;
    #1;
    chk("t5_in_ready_free", in_ready, 1);
    tick();
    valid_in = 1'b0;
    sorted   = '0;
    chk("t5_overflow", overflow, 0);
    repeat (24) tick();
    exp = '{1, 2, 3, 4, 5, 6, 7, 8, 11, 12, 13, 14, 15, 16, 17, 18,
            21, 22, 23, 24, 25, 26, 27, 28};
    chk_got("t5_stream", exp);

    // T6 reset in the middle of a drain
    got.delete();
    out_ready = 1'b1;
    pulse(seq(0));
    repeat (3) tick();
    do_reset();
    chk("t6_valid_after_rst", out_valid, 0);
    chk("t6_ovf_after_rst", overflow, 0);
    chk("t6_data_after_rst", out_data, 0);
    got.delete();
    pulse(seq(20));
    chk("t6_fresh_data", out_data, 21);
    chk("t6_fresh_idx", out_idx, 0);
    repeat (10) tick();
    exp = '{21, 22, 23, 24, 25, 26, 27, 28};
    chk_got("t6_stream", exp);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
